// File: rtl/pmc_dc_sweep_ctrl_if.sv
// rtl/pmc_dc_sweep_ctrl_if.sv - control, configuration and monitor signals of the threshold-sweep sequencer
interface pmc_dc_sweep_ctrl_if #(
    parameter int TH_W    = 8,
    parameter int RES_W   = 4,
    parameter int DWELL_W = 16
);
    logic               start;
    logic               abort;
    logic [TH_W-1:0]    th_start;
    logic [TH_W-1:0]    th_stop;
    logic [TH_W-1:0]    th_step;
    logic [DWELL_W-1:0] dwell;
    logic [RES_W-1:0]   res_sweep;
    logic [RES_W-1:0]   res_man;
    logic [TH_W-1:0]    th_man;
    logic               cmp_in;
    logic [RES_W-1:0]   res;
    logic [TH_W-1:0]    th;
    logic               busy;
    logic               done;
    logic               found;
    logic [TH_W-1:0]    trip_th;
    logic               aborted;

    modport master (
        output start, abort, th_start, th_stop, th_step, dwell,
               res_sweep, res_man, th_man, cmp_in,
        input  res, th, busy, done, found, trip_th, aborted
    );

    modport slave (
        input  start, abort, th_start, th_stop, th_step, dwell,
               res_sweep, res_man, th_man, cmp_in,
        output res, th, busy, done, found, trip_th, aborted
    );
endinterface

// File: rtl/pmc_dc_sweep_ctrl.sv
// rtl/pmc_dc_sweep_ctrl.sv - steps the monitor threshold over a range and reports the first comparator trip
module pmc_dc_sweep_ctrl #(
    parameter int TH_W    = 8,
    parameter int RES_W   = 4,
    parameter int DWELL_W = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    pmc_dc_sweep_ctrl_if.slave  sif
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [TH_W-1:0]    th_cur_q,  th_cur_d;
    logic [TH_W-1:0]    th_stop_q, th_stop_d;
    logic [TH_W-1:0]    th_step_q, th_step_d;
    logic [DWELL_W-1:0] dwell_q,   dwell_d;
    logic [DWELL_W-1:0] cnt_q,     cnt_d;
    logic [RES_W-1:0]   res_q,     res_d;
    logic               found_q,   found_d;
    logic [TH_W-1:0]    trip_th_q, trip_th_d;
    logic               aborted_q, aborted_d;

    logic [TH_W-1:0]    step_eff;
    logic [DWELL_W-1:0] dwell_eff;
    logic [TH_W:0]      th_sum;
    logic               busy;

    // Zero step/dwell would stall the sweep, so both are promoted to 1 on capture.
    assign step_eff  = (sif.th_step == '0) ? TH_W'(1)    : sif.th_step;
    assign dwell_eff = (sif.dwell == '0)   ? DWELL_W'(1) : sif.dwell;
    // One bit wider so a step past the top code ends the sweep instead of wrapping.
    assign th_sum    = {1'b0, th_cur_q} + {1'b0, th_step_q};

    always_comb begin
        state_d   = state_q;
        th_cur_d  = th_cur_q;
        th_stop_d = th_stop_q;
        th_step_d = th_step_q;
        dwell_d   = dwell_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        found_d   = found_q;
        trip_th_d = trip_th_q;
        aborted_d = aborted_q;

        case (state_q)
            IDLE: begin
                if (sif.start && !sif.abort) begin
                    th_cur_d  = sif.th_start;
                    th_stop_d = sif.th_stop;
                    th_step_d = step_eff;
                    dwell_d   = dwell_eff;
                    cnt_d     = dwell_eff - DWELL_W'(1);
                    res_d     = sif.res_sweep;
                    found_d   = 1'b0;
                    aborted_d = 1'b0;
                    trip_th_d = '0;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (sif.abort) begin
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (sif.cmp_in) begin
                    found_d   = 1'b1;
                    trip_th_d = th_cur_q;
                    state_d   = DONE;
                end else if ((th_cur_q >= th_stop_q) || (th_sum > {1'b0, th_stop_q})) begin
                    state_d = DONE;
                end else begin
                    th_cur_d = th_sum[TH_W-1:0];
                    cnt_d    = dwell_q - DWELL_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            th_cur_q  <= '0;
            th_stop_q <= '0;
            th_step_q <= '0;
            dwell_q   <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            found_q   <= 1'b0;
            trip_th_q <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            th_cur_q  <= th_cur_d;
            th_stop_q <= th_stop_d;
            th_step_q <= th_step_d;
            dwell_q   <= dwell_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            found_q   <= found_d;
            trip_th_q <= trip_th_d;
            aborted_q <= aborted_d;
        end
    end

    assign busy        = (state_q == SETTLE);
    assign sif.busy    = busy;
    assign sif.done    = (state_q == DONE);
    assign sif.th      = busy ? th_cur_q : sif.th_man;
    assign sif.res     = busy ? res_q    : sif.res_man;
    assign sif.found   = found_q;
    assign sif.trip_th = trip_th_q;
    assign sif.aborted = aborted_q;
endmodule

// File: tb/tb_pmc_dc_sweep_ctrl.sv
// tb/tb_pmc_dc_sweep_ctrl.sv - randomized sweep bench against a threshold-list reference model
module tb_pmc_dc_sweep_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    pmc_dc_sweep_ctrl_if #(.TH_W(8), .RES_W(4), .DWELL_W(16)) sif ();

    pmc_dc_sweep_ctrl #(.TH_W(8), .RES_W(4), .DWELL_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        sif.th_man    = 8'($urandom);
        sif.res_man   = 4'($urandom);
        sif.th_start  = 8'($urandom);
        sif.th_stop   = 8'($urandom);
        sif.th_step   = 8'($urandom);
        sif.dwell     = 16'($urandom_range(0, 5));
        sif.res_sweep = 4'($urandom);
    endtask

    // Reference: the sweep visits start, start+step, ... until the current code is at or beyond
    // stop or the next code would pass stop; each code is held dwell cycles and cmp_in is only
    // looked at in the last of them. tt = index of the code whose sample trips (-1: none),
    // ab = settle cycle index at which abort is pulsed (-1: none).
    task automatic run_sweep(input int ts, input int te, input int tp, input int dw,
                             input int rs, input int tt, input int ab);
        int ths[$];
        int se, de, v, nst, settle, k;
        bit abt, exp_found;
        int exp_trip;

        se = (tp == 0) ? 1 : tp;
        de = (dw == 0) ? 1 : dw;
        v  = ts;
        forever begin
            ths.push_back(v);
            if (v >= te || v + se > te) break;
            v = v + se;
        end
        exp_found = (tt >= 0) && (tt < ths.size());
        nst       = exp_found ? tt + 1 : ths.size();
        exp_trip  = exp_found ? ths[tt] : 0;
        settle    = nst * de;
        abt       = (ab >= 0) && (ab < settle);
        if (abt) begin
            settle    = ab + 1;
            exp_found = 1'b0;
            exp_trip  = 0;
        end

        sif.th_start  = 8'(ts);
        sif.th_stop   = 8'(te);
        sif.th_step   = 8'(tp);
        sif.dwell     = 16'(dw);
        sif.res_sweep = 4'(rs);
        sif.th_man    = 8'($urandom);
        sif.res_man   = 4'($urandom);
        sif.start     = 1'b1;
        sif.abort     = 1'b0;
        sif.cmp_in    = 1'($urandom);
        @(negedge clk);
        check("start_busy", 32'(sif.busy), 32'd0);
        check("start_th", 32'(sif.th), 32'(sif.th_man));
        next_cycle();

        for (int j = 0; j < settle; j++) begin
            k = j / de;
            scramble_inputs();
            sif.start  = ($urandom_range(0, 7) == 0);
            sif.abort  = (j == ab);
            sif.cmp_in = (j % de == de - 1) ? (k == tt) : 1'($urandom);
            @(negedge clk);
            check("sw_busy", 32'(sif.busy), 32'd1);
            check("sw_done", 32'(sif.done), 32'd0);
            check("sw_th", 32'(sif.th), 32'(ths[k]));
            check("sw_res", 32'(sif.res), 32'(rs));
            next_cycle();
        end

        sif.start  = 1'b0;
        sif.abort  = 1'($urandom);
        sif.th_man = 8'($urandom);
        sif.res_man = 4'($urandom);
        @(negedge clk);
        check("end_busy", 32'(sif.busy), 32'd0);
        check("end_done", 32'(sif.done), 32'(!abt));
        check("end_th", 32'(sif.th), 32'(sif.th_man));
        check("end_res", 32'(sif.res), 32'(sif.res_man));
        check("end_found", 32'(sif.found), 32'(exp_found));
        check("end_trip", 32'(sif.trip_th), 32'(exp_trip));
        check("end_aborted", 32'(sif.aborted), 32'(abt));
        next_cycle();

        sif.abort = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(sif.busy), 32'd0);
        check("idle_done", 32'(sif.done), 32'd0);
        check("idle_found", 32'(sif.found), 32'(exp_found));
        check("idle_trip", 32'(sif.trip_th), 32'(exp_trip));
        check("idle_aborted", 32'(sif.aborted), 32'(abt));
        next_cycle();
    endtask

    initial begin
        sif.start     = 1'b0;
        sif.abort     = 1'b0;
        sif.th_start  = 8'h00;
        sif.th_stop   = 8'h00;
        sif.th_step   = 8'h00;
        sif.dwell     = 16'd0;
        sif.res_sweep = 4'h0;
        sif.th_man    = 8'h33;
        sif.res_man   = 4'h5;
        sif.cmp_in    = 1'b0;

        #12;
        check("rst_th", 32'(sif.th), 32'h33);
        check("rst_res", 32'(sif.res), 32'h5);
        check("rst_busy", 32'(sif.busy), 32'd0);
        check("rst_done", 32'(sif.done), 32'd0);
        check("rst_found", 32'(sif.found), 32'd0);
        check("rst_trip", 32'(sif.trip_th), 32'd0);
        check("rst_aborted", 32'(sif.aborted), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        check("idle_th", 32'(sif.th), 32'h33);
        check("idle_res", 32'(sif.res), 32'h5);
        next_cycle();

        run_sweep(8'h10, 8'h14, 2, 3, 4'h9, -1, -1);
        run_sweep(8'h00, 8'hFF, 8'h10, 1, 4'h3, 3, -1);
        run_sweep(8'hFE, 8'hFE, 0, 0, 4'hA, -1, -1);
        run_sweep(8'hF0, 8'hFF, 8'h20, 2, 4'h1, -1, -1);
        run_sweep(8'h10, 8'h14, 2, 3, 4'h7, -1, 3);
        run_sweep(8'h40, 8'h20, 5, 2, 4'hC, -1, -1);

        sif.start = 1'b1;
        sif.abort = 1'b1;
        next_cycle();
        sif.start = 1'b0;
        sif.abort = 1'b0;
        @(negedge clk);
        check("sa_busy", 32'(sif.busy), 32'd0);
        check("sa_th", 32'(sif.th), 32'(sif.th_man));
        next_cycle();

        for (int n = 0; n < 60; n++) begin
            int tp, tt, ab;
            tp = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 255) : $urandom_range(0, 8);
            tt = ($urandom_range(0, 1) == 1) ? -1 : $urandom_range(0, 6);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
            run_sweep($urandom_range(0, 255), $urandom_range(0, 255), tp,
                      $urandom_range(0, 4), $urandom_range(0, 15), tt, ab);
        end

        sif.th_start  = 8'h10;
        sif.th_stop   = 8'hF0;
        sif.th_step   = 8'h01;
        sif.dwell     = 16'd4;
        sif.res_sweep = 4'hE;
        sif.cmp_in    = 1'b0;
        sif.start     = 1'b1;
        next_cycle();
        sif.start = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("prerst_busy", 32'(sif.busy), 32'd1);
        next_cycle();
        rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(sif.busy), 32'd0);
        check("mrst_done", 32'(sif.done), 32'd0);
        check("mrst_found", 32'(sif.found), 32'd0);
        check("mrst_trip", 32'(sif.trip_th), 32'd0);
        check("mrst_aborted", 32'(sif.aborted), 32'd0);
        check("mrst_th", 32'(sif.th), 32'(sif.th_man));
        check("mrst_res", 32'(sif.res), 32'(sif.res_man));
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        run_sweep(8'h20, 8'h30, 4, 2, 4'h6, 2, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
